qspi_flash_burst_reader: RTL and testbench
==========================================

Name: qspi_flash_burst_reader

Overview:
Parametrised successor to the single-byte quad flash reader. It reads a burst of 1..2^LEN_W bytes from SPI NOR in one of three read modes: single READ, FAST READ or quad I/O. It generates its own gated SCLK so the consumer can stall the stream with valid/ready backpressure. It sits between the board flash pins (top-level tristate) and consumers such as UART dump or boot loaders.

Parameters:
ADDR_W, 24, address width; only 24 or 32 are legal. 32 selects the 4-byte opcodes 0x13, 0x0C and 0xEC.
LEN_W, 8, width of the burst length field.
SCLK_HALF, 1, number of clk cycles per SCLK half-period (>=1).
QUAD_DUMMY, 4, number of dummy SCLKs after the mode byte in quad mode.
FAST_DUMMY, 8, number of dummy SCLKs in FAST READ mode.
CS_HIGH, 4, minimum number of clk cycles cs_n stays high between bursts.

Ports:
clk  in  1  system clock
rstn  in  1  synchronous active-low reset
start  in  1  burst request; sampled only in IDLE
mode  in  2  0 = READ (0x03), 1 = FAST READ (0x0B), 2 = quad I/O (0xEB), 3 = treated as 0
addr  in  ADDR_W  start byte address; latched on start
len  in  LEN_W  burst length minus one; latched on start
abort  in  1  end the burst after the byte currently in flight
busy  out  1  high from start acceptance until the return to IDLE
out_data  out  8  read byte
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts the byte
done  out  1  one-cycle pulse on burst completion or abort
sclk  out  1  flash clock, SPI mode 0
cs_n  out  1  flash chip select, active low
io_out  out  4  IO0..IO3 drive values
io_oe  out  4  per-pin output enable
io_in  in  4  IO0..IO3 sampled values

Behaviour:
- Reset (rstn = 0 at a clk edge) aborts immediately from any state. Reset values: cs_n = 1, sclk = 0, io_oe = 0, io_out = 4'hF, out_valid = 0, out_data = 0, busy = 0, done = 0, state = IDLE. The CS_HIGH counter is preloaded so start is not accepted in the first CS_HIGH cycles after reset.
- Timing base: a tick fires every SCLK_HALF clk cycles while cs_n = 0.
  - sclk toggles on each tick, except when stalled.
  - Outputs change only on ticks that drive sclk 1→0.
  - io_in is sampled on ticks that drive sclk 0→1 (the same edge the flash drives on falling, so data is a half-period old).
- State IDLE:
  - If start=1 and the CS_HIGH time is satisfied, latch addr, len and mode; busy=1; go to CMD.
  - cs_n goes 0 in the cycle after start is accepted.
  - The first data bit is valid before the first sclk rising edge.
- State CMD: 8 SCLKs. Opcode shifted MSB-first on IO0. io_oe = 4'b0001; io_out[3:2] = 2'b11 so WP/HOLD are held high.
- State ADDR:
  - Single modes: ADDR_W SCLKs on IO0.
  - Quad mode: ADDR_W/4 SCLKs, nibbles MSB-first on IO3..IO0 with io_oe = 4'hF, followed by 2 SCLKs of mode byte 0xFF.
- State DUMMY: FAST_DUMMY SCLKs (mode 1) or QUAD_DUMMY SCLKs (mode 2), with io_oe = 0. Mode 0 skips DUMMY.
- State DATA:
  - Single modes: 8 SCLKs per byte, sampled from IO1.
  - Quad mode: 2 SCLKs per byte, sampled from IO3..IO0, high nibble first.
  - io_oe = 0.
  - When a byte is complete, it goes to out_data and out_valid=1 in the same cycle.
- Backpressure:
  - out_valid stays high and out_data stays stable until out_valid & out_ready.
  - If the next byte would complete while out_valid is still high, sclk is held low before the rising edge of that byte's last bit, and stays low until the pending byte is accepted.
  - No byte is ever dropped or duplicated.
- Byte counter: counts down from the latched len. After byte len+1 is transferred, go to END. Length arithmetic uses LEN_W+1 bits, so len = all-ones yields 2^LEN_W bytes with no wrap.
- Abort: sampled in any non-IDLE state.
  - In CMD, ADDR or DUMMY: go to END at the next sclk-low point.
  - In DATA: the in-flight byte is completed and presented, then go to END.
  - abort in IDLE is ignored.
- State END:
  - Entered with sclk low; cs_n=1 and io_oe=0.
  - Waits until the last out_valid byte is accepted and CS_HIGH cycles have elapsed.
  - Then pulses done for 1 cycle and drops busy in that same cycle.
  - start in the same cycle is not accepted; it is accepted from the next cycle.
- Flash address wrap at the top of the device is the flash's behaviour; the block only sends the start address.

Test Plan:
1. mode=0, addr=0x400000, len=0, SCLK_HALF=1, flash model byte 0xA5 → IO0 carries 0x03,0x40,0x00,0x00 MSB-first; 40 SCLKs total; out_data=0xA5, out_valid=1; done pulse; cs_n high for >=4 clk cycles.
2. mode=2, addr=0x000010, len=3, out_ready tied 1, model bytes 0x11,0x22,0x33,0x44 → 8+6+2+4+8 = 28 SCLKs; IO3..IO0 nibbles 0,0,0,0,1,0 then F,F; four bytes in order; single done pulse.
3. mode=1, len=7, out_ready low for 50 cycles after byte 2 → sclk frozen low while out_valid is held; byte 2 stable; all 8 bytes delivered with no loss or duplicate.
4. mode=2, len=255, abort asserted mid-byte 5 → byte 5 delivered, no byte 6; cs_n=1; done pulse; busy falls.
5. rstn=0 during ADDR → at the next edge cs_n=1, io_oe=0, out_valid=0, busy=0; a new start after CS_HIGH cycles completes normally.
6. ADDR_W=32, mode=2, addr=0x01234567, SCLK_HALF=3 → opcode 0xEC; 8 address nibbles; sclk period is 6 clk cycles; data matches the model.

Source files
------------

// File: rtl/qspi_flash_burst_reader.sv
// rtl/qspi_flash_burst_reader.sv - burst reader for SPI NOR in READ, FAST READ or quad I/O mode
// Generates a gated SCLK so the byte stream can be stalled by out_ready.
module qspi_flash_burst_reader #(
  parameter int ADDR_W     = 24,
  parameter int LEN_W      = 8,
  parameter int SCLK_HALF  = 1,
  parameter int QUAD_DUMMY = 4,
  parameter int FAST_DUMMY = 8,
  parameter int CS_HIGH    = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  output logic              busy,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done,
  output logic              sclk,
  output logic              cs_n,
  output logic [3:0]        io_out,
  output logic [3:0]        io_oe,
  input  logic [3:0]        io_in
);

  localparam int SH_W  = 8 + ADDR_W;
  localparam int DIV_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int CH_W  = $clog2(CS_HIGH + 2);
  localparam int CNT_W = 16;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCLK_HALF - 1);
  localparam logic [CH_W-1:0]  CH_INIT = CH_W'(CS_HIGH);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_END} state_t;

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [LEN_W:0]    bytes_q, bytes_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic [7:0]        rx_q, rx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              sclk_q, sclk_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;
  logic              fin_q, fin_d;

  logic              tick, rise, fall, abort_any;
  logic [1:0]        mode_eff;
  logic [CNT_W-1:0]  data_top;

  function automatic logic [7:0] opcode_for(input logic [1:0] m);
    case (m)
      2'd1:    return (ADDR_W == 32) ? 8'h0C : 8'h0B;
      2'd2:    return (ADDR_W == 32) ? 8'hEC : 8'hEB;
      default: return (ADDR_W == 32) ? 8'h13 : 8'h03;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      mode_q      <= 2'd0;
      bytes_q     <= '0;
      sh_q        <= '1;
      rx_q        <= 8'h00;
      cnt_q       <= '0;
      div_q       <= '0;
      sclk_q      <= 1'b0;
      ch_q        <= CH_INIT;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      fin_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      bytes_q     <= bytes_d;
      sh_q        <= sh_d;
      rx_q        <= rx_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      sclk_q      <= sclk_d;
      ch_q        <= ch_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      fin_q       <= fin_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    bytes_d     = bytes_q;
    sh_d        = sh_q;
    rx_d        = rx_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    sclk_d      = sclk_q;
    ch_d        = ch_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q & ~out_ready;
    done_d      = 1'b0;
    abort_d     = abort_q | (abort & (state_q != S_IDLE));
    fin_d       = fin_q;
    tick        = 1'b0;
    rise        = 1'b0;
    fall        = 1'b0;
    abort_any   = abort | abort_q;
    mode_eff    = (mode == 2'd3) ? 2'd0 : mode;
    data_top    = (mode_q == 2'd2) ? CNT_W'(1) : CNT_W'(7);

    if (state_q inside {S_CMD, S_ADDR, S_DUMMY, S_DATA}) begin
      tick  = (div_q == DIV_MAX);
      div_d = tick ? '0 : div_q + 1'b1;
      // Hold SCLK low ahead of the rising edge that would complete a byte with nowhere to go.
      if (tick && !sclk_q && state_q == S_DATA && cnt_q == '0 && out_valid_q && !out_ready) begin
        tick  = 1'b0;
        div_d = div_q;
      end
      rise = tick & ~sclk_q;
      fall = tick & sclk_q;
      if (tick) sclk_d = ~sclk_q;
    end

    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        fin_d   = 1'b0;
        if (ch_q != '0) ch_d = ch_q - 1'b1;
        if (start && ch_q == '0 && !done_q) begin
          state_d = S_CMD;
          mode_d  = mode_eff;
          bytes_d = {1'b0, len};
          sh_d    = {opcode_for(mode_eff), addr};
          cnt_d   = CNT_W'(7);
          div_d   = '0;
          sclk_d  = 1'b0;
        end
      end
      S_CMD: begin
        if (fall) begin
          sh_d = {sh_q[SH_W-2:0], 1'b1};
          if (cnt_q == '0) begin
            state_d = S_ADDR;
            cnt_d   = (mode_q == 2'd2) ? CNT_W'(ADDR_W / 4 + 1) : CNT_W'(ADDR_W - 1);
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      S_ADDR: begin
        if (fall) begin
          // Ones shifted in behind the quad address form the 0xFF mode byte.
          if (mode_q == 2'd2) sh_d = {sh_q[SH_W-5:0], 4'hF};
          else                sh_d = {sh_q[SH_W-2:0], 1'b1};
          if (cnt_q == '0) begin
            if (mode_q == 2'd1 && FAST_DUMMY > 0) begin
              state_d = S_DUMMY;
              cnt_d   = CNT_W'(FAST_DUMMY - 1);
            end else if (mode_q == 2'd2 && QUAD_DUMMY > 0) begin
              state_d = S_DUMMY;
              cnt_d   = CNT_W'(QUAD_DUMMY - 1);
            end else begin
              state_d = S_DATA;
              cnt_d   = data_top;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      S_DUMMY: begin
        if (fall) begin
          if (cnt_q == '0) begin
            state_d = S_DATA;
            cnt_d   = data_top;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      S_DATA: begin
        if (rise) begin
          rx_d = (mode_q == 2'd2) ? {rx_q[3:0], io_in} : {rx_q[6:0], io_in[1]};
          if (cnt_q == '0) begin
            out_data_d  = rx_d;
            out_valid_d = 1'b1;
            if (bytes_q == '0 || abort_any) fin_d = 1'b1;
            else                            bytes_d = bytes_q - 1'b1;
          end
        end
        if (fall) begin
          if (fin_q)               state_d = S_END;
          else if (cnt_q == '0)    cnt_d = data_top;
          else                     cnt_d = cnt_q - 1'b1;
        end
      end
      S_END: begin
        if (ch_q != '0) begin
          ch_d = ch_q - 1'b1;
        end else if (!out_valid_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q inside {S_CMD, S_ADDR, S_DUMMY} && abort_any && (!sclk_q || fall)) begin
      state_d = S_END;
    end

    if (state_d == S_END && state_q != S_END) begin
      ch_d   = CH_INIT;
      sclk_d = 1'b0;
      div_d  = '0;
    end
  end

  always_comb begin
    io_oe  = 4'h0;
    io_out = 4'hF;
    case (state_q)
      S_CMD: begin
        io_oe  = 4'b0001;
        io_out = {3'b111, sh_q[SH_W-1]};
      end
      S_ADDR: begin
        if (mode_q == 2'd2) begin
          io_oe  = 4'hF;
          io_out = sh_q[SH_W-1 -: 4];
        end else begin
          io_oe  = 4'b0001;
          io_out = {3'b111, sh_q[SH_W-1]};
        end
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign cs_n      = (state_q == S_IDLE) || (state_q == S_END);
  assign sclk      = sclk_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_qspi_flash_burst_reader.sv
// tb/tb_qspi_flash_burst_reader.sv - scoreboard bench for qspi_flash_burst_reader with a flash model
module tb_qspi_flash_burst_reader;

  logic        clk = 1'b0;
  logic        rstn, start_a, start_b, abort, out_ready, sel;
  logic [1:0]  mode, t_mode;
  logic [23:0] addr_a;
  logic [31:0] addr_b;
  logic [7:0]  len;
  logic [3:0]  io_in;

  logic       busy_a, ov_a, done_a, sclk_a, csn_a;
  logic [7:0] od_a;
  logic [3:0] ioo_a, ioe_a;
  logic       busy_b, ov_b, done_b, sclk_b, csn_b;
  logic [7:0] od_b;
  logic [3:0] ioo_b, ioe_b;

  logic       m_busy, m_ov, m_done, m_sclk, m_csn;
  logic [7:0] m_od;
  logic [3:0] m_ioo, m_ioe;

  int checks = 0, errors = 0;
  int got_cnt = 0, done_cnt = 0;
  logic [7:0] exp_q[$];

  int cyc = 0, rise_cnt = 0, hi_cnt = 100, burst_rises = 0, viol = 0, per_bad = 0, last_rise = 0;
  logic [7:0]  opc, mb;
  logic [31:0] adr;
  logic        sclk_prev = 1'b0, cs_prev = 1'b1, hold_prev = 1'b0;
  logic [7:0]  data_prev = 8'h00;
  logic [7:0]  mem [256];

  always #5 clk = ~clk;

  qspi_flash_burst_reader #(.ADDR_W(24), .SCLK_HALF(1)) dut_a (
    .clk(clk), .rstn(rstn), .start(start_a), .mode(mode), .addr(addr_a), .len(len),
    .abort(abort), .busy(busy_a), .out_data(od_a), .out_valid(ov_a), .out_ready(out_ready),
    .done(done_a), .sclk(sclk_a), .cs_n(csn_a), .io_out(ioo_a), .io_oe(ioe_a), .io_in(io_in));

  qspi_flash_burst_reader #(.ADDR_W(32), .SCLK_HALF(3)) dut_b (
    .clk(clk), .rstn(rstn), .start(start_b), .mode(mode), .addr(addr_b), .len(len),
    .abort(abort), .busy(busy_b), .out_data(od_b), .out_valid(ov_b), .out_ready(out_ready),
    .done(done_b), .sclk(sclk_b), .cs_n(csn_b), .io_out(ioo_b), .io_oe(ioe_b), .io_in(io_in));

  assign m_busy = sel ? busy_b : busy_a;
  assign m_ov   = sel ? ov_b   : ov_a;
  assign m_done = sel ? done_b : done_a;
  assign m_sclk = sel ? sclk_b : sclk_a;
  assign m_csn  = sel ? csn_b  : csn_a;
  assign m_od   = sel ? od_b   : od_a;
  assign m_ioo  = sel ? ioo_b  : ioo_a;
  assign m_ioe  = sel ? ioe_b  : ioe_a;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int hdr_ctrl();
    int aw = sel ? 32 : 24;
    return (t_mode == 2'd2) ? 8 + aw / 4 + 2 : 8 + aw;
  endfunction

  function automatic int hdr_total();
    return hdr_ctrl() + ((t_mode == 2'd1) ? 8 : (t_mode == 2'd2) ? 4 : 0);
  endfunction

  // Flash model: captures the header on SCLK rising, drives read data after SCLK falling.
  always @(negedge clk) begin
    int n, b, ix, aw, half;
    logic [7:0] d;
    cyc++;
    aw   = sel ? 32 : 24;
    half = sel ? 3 : 1;
    if (m_csn) begin
      if (!cs_prev) burst_rises = rise_cnt;
      hi_cnt++;
      rise_cnt = 0;
      io_in = 4'h0;
    end else begin
      if (cs_prev) begin
        if (hi_cnt < 4) viol++;
        hi_cnt = 0; opc = 8'h00; adr = 32'h0; mb = 8'h00;
      end
      n = rise_cnt;
      if (m_sclk && !sclk_prev) begin
        if (n < 8) begin
          opc = {opc[6:0], m_ioo[0]};
          if (m_ioe != 4'b0001 || m_ioo[3:2] != 2'b11) viol++;
        end else if (n < hdr_ctrl()) begin
          if (t_mode == 2'd2) begin
            if (m_ioe != 4'hF) viol++;
            if (n < 8 + aw / 4) adr = {adr[27:0], m_ioo};
            else                mb  = {mb[3:0], m_ioo};
          end else begin
            if (m_ioe != 4'b0001) viol++;
            adr = {adr[30:0], m_ioo[0]};
          end
        end else if (m_ioe != 4'h0) begin
          viol++;
        end
        if (n > 0 && n < hdr_total() && (cyc - last_rise) != 2 * half) per_bad++;
        last_rise = cyc;
        rise_cnt++;
      end else if (!m_sclk && sclk_prev && n >= hdr_total()) begin
        b = n - hdr_total();
        if (t_mode == 2'd2) begin
          ix = (int'(adr[7:0]) + b / 2) % 256;
          d  = mem[ix];
          io_in = (b % 2 == 0) ? d[7:4] : d[3:0];
        end else begin
          ix = (int'(adr[7:0]) + b / 8) % 256;
          d  = mem[ix];
          io_in = {2'b00, d[7 - b % 8], 1'b0};
        end
      end
    end
    cs_prev   = m_csn;
    sclk_prev = m_sclk;
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (m_done) done_cnt++;
    if (hold_prev) begin
      check("hold_valid", m_ov, 1);
      check("hold_data", m_od, data_prev);
    end
    if (m_ov && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_byte", m_od, 64'hFFFF);
      end else begin
        check("byte", m_od, exp_q.pop_front());
      end
      got_cnt++;
    end
    hold_prev = m_ov && !out_ready;
    data_prev = m_od;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!m_busy && n < 200) begin
      @(posedge clk); #1; n++;
    end
    start_a = 1'b0;
    start_b = 1'b0;
    check("start_accept", m_busy, 1);
  endtask

  task automatic start_burst(input logic s, input logic [1:0] md, input logic [31:0] a, input logic [7:0] ln);
    sel = s; t_mode = md; mode = md; addr_a = a[23:0]; addr_b = a; len = ln;
    if (s) start_b = 1'b1; else start_a = 1'b1;
    wait_busy();
  endtask

  task automatic wait_done(input int d0, input int budget);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk); #1; n++;
    end
    cycles(3);
    check("done_pulse", done_cnt, d0 + 1);
    check("busy_after", m_busy, 0);
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int d0, g0, r0, n;
    rstn = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0; out_ready = 1'b1;
    mode = 2'd0; t_mode = 2'd0; addr_a = '0; addr_b = '0; len = '0; sel = 1'b0; io_in = 4'h0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    mem[8'h00] = 8'hA5;
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
    cycles(2);
    check("reset_state", {m_csn, m_sclk, m_ioe, m_ioo, m_ov, m_od, m_busy, m_done},
          {1'b1, 1'b0, 4'h0, 4'hF, 1'b0, 8'h00, 1'b0, 1'b0});

    // 1: single READ of one byte, start held from reset release
    exp_q.push_back(8'hA5);
    mode = 2'd0; t_mode = 2'd0; addr_a = 24'h400000; len = 8'd0; start_a = 1'b1;
    rstn = 1'b1;
    d0 = done_cnt;
    cycles(3);
    check("cs_high_preload", m_busy, 0);
    wait_busy();
    wait_done(d0, 2000);
    check("t1_opcode", opc, 8'h03);
    check("t1_addr", adr, 32'h400000);
    check("t1_sclks", burst_rises, 40);

    // 2: quad I/O, 4 bytes, no backpressure
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    d0 = done_cnt;
    start_burst(1'b0, 2'd2, 32'h000010, 8'd3);
    wait_done(d0, 2000);
    check("t2_opcode", opc, 8'hEB);
    check("t2_addr", adr, 32'h000010);
    check("t2_mode_byte", mb, 8'hFF);
    check("t2_sclks", burst_rises, 28);

    // 3: FAST READ, 8 bytes, consumer stalls after the first byte
    exp_q.push_back(8'hC3); exp_q.push_back(8'hCA); exp_q.push_back(8'hD1); exp_q.push_back(8'hD8);
    exp_q.push_back(8'hDF); exp_q.push_back(8'hE6); exp_q.push_back(8'hED); exp_q.push_back(8'hF4);
    d0 = done_cnt; g0 = got_cnt;
    start_burst(1'b0, 2'd1, 32'h000040, 8'd7);
    n = 0;
    while (got_cnt < g0 + 1 && n < 2000) begin cycles(1); n++; end
    check("t3_first_byte", got_cnt, g0 + 1);
    out_ready = 1'b0;
    cycles(40);
    r0 = rise_cnt;
    cycles(10);
    check("t3_sclk_frozen", rise_cnt, r0);
    check("t3_sclk_low", m_sclk, 0);
    check("t3_held_byte", {m_ov, m_od}, {1'b1, 8'hCA});
    out_ready = 1'b1;
    wait_done(d0, 3000);
    check("t3_opcode", opc, 8'h0B);
    check("t3_sclks", burst_rises, 104);

    // 4: quad, len 255, abort during byte 5
    exp_q.push_back(8'hE3); exp_q.push_back(8'hEA); exp_q.push_back(8'hF1);
    exp_q.push_back(8'hF8); exp_q.push_back(8'hFF);
    d0 = done_cnt; g0 = got_cnt;
    start_burst(1'b0, 2'd2, 32'h000020, 8'd255);
    n = 0;
    while (got_cnt < g0 + 4 && n < 2000) begin cycles(1); n++; end
    abort = 1'b1;
    cycles(1);
    abort = 1'b0;
    wait_done(d0, 2000);
    cycles(20);
    check("t4_byte_count", got_cnt, g0 + 5);
    check("t4_cs_n", m_csn, 1);

    // 5: reset during the address phase, then a clean burst
    start_burst(1'b0, 2'd0, 32'h000080, 8'd1);
    n = 0;
    while (rise_cnt < 12 && n < 500) begin cycles(1); n++; end
    rstn = 1'b0;
    cycles(1);
    check("t5_reset_abort", {m_csn, m_ioe, m_ov, m_busy}, {1'b1, 4'h0, 1'b0, 1'b0});
    rstn = 1'b1;
    exp_q.push_back(8'h83); exp_q.push_back(8'h8A);
    d0 = done_cnt;
    start_burst(1'b0, 2'd0, 32'h000080, 8'd1);
    wait_done(d0, 2000);
    check("t5_addr", adr, 32'h000080);

    // 6: 32-bit address, quad, SCLK_HALF = 3
    exp_q.push_back(8'hD4); exp_q.push_back(8'hDB);
    d0 = done_cnt;
    start_burst(1'b1, 2'd2, 32'h01234567, 8'd1);
    wait_done(d0, 4000);
    check("t6_opcode", opc, 8'hEC);
    check("t6_addr", adr, 32'h01234567);
    check("t6_mode_byte", mb, 8'hFF);
    check("t6_sclks", burst_rises, 26);

    check("pin_protocol", viol, 0);
    check("sclk_period", per_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
